// File: rtl/canvas_layer.sv
// canvas_layer: one drawable overlay plane for the compositor.
// Colour memory with a registered one-cycle read port. The write engine
// stamps BRUSH x BRUSH squares or clears the whole plane to COLOR_NONE.
// Optional build macro: CANVAS_CLEAR_ON_RESET_EN. When it is defined, the
// plane clears itself after every reset.
module canvas_layer #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int BRUSH       = 3,
    parameter int COLOR_WIDTH = 4,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(WIDTH)-1:0]   request_x,
    input  logic [$clog2(HEIGHT)-1:0]  request_y,
    output logic [COLOR_WIDTH-1:0]     canvas_color,
    output logic                       canvas_visible,
    input  logic                       visible_toggle,
    input  logic                       draw_req,
    input  logic [$clog2(WIDTH)-1:0]   draw_x,
    input  logic [$clog2(HEIGHT)-1:0]  draw_y,
    input  logic [COLOR_WIDTH-1:0]     draw_color,
    input  logic                       clear_req,
    output logic                       busy
);

    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int BW    = (BRUSH > 1) ? $clog2(BRUSH) : 1;
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_PAINT,
        STATE_CLEAR
    } state_t;

`ifdef CANVAS_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = STATE_CLEAR;
`else
    localparam state_t RESET_STATE = STATE_IDLE;
`endif

    state_t state_q, state_d;

    logic [COLOR_WIDTH-1:0] mem [DEPTH];

    // Latched stamp parameters (data only, no reset needed).
    logic [XW-1:0]          lx;
    logic [YW-1:0]          ly;
    logic [COLOR_WIDTH-1:0] lc;

    logic [BW-1:0] bx, by;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;

    logic                   accept_draw, start_clear;
    logic                   bx_last, by_last, cx_last, cy_last;
    logic [XW:0]            px, wx;
    logic [YW:0]            py, wy;
    logic                   we;
    logic [AW-1:0]          wa;
    logic [COLOR_WIDTH-1:0] wd;
    logic                   rd_ok;
    logic [AW-1:0]          ra;

    // Stamp pixel coordinates, one bit wider than the plane so edges never wrap.
    assign px = (XW+1)'(lx) + (XW+1)'(bx);
    assign py = (YW+1)'(ly) + (YW+1)'(by);

    assign bx_last = (32'(bx) == BRUSH - 1);
    assign by_last = (32'(by) == BRUSH - 1);
    assign cx_last = (32'(cx) == WIDTH - 1);
    assign cy_last = (32'(cy) == HEIGHT - 1);

    assign busy = (state_q != STATE_IDLE);

    // Next-state logic and write-port selection.
    always_comb begin
        state_d     = state_q;
        accept_draw = 1'b0;
        start_clear = 1'b0;
        we          = 1'b0;
        wx          = '0;
        wy          = '0;
        wd          = COLOR_NONE;
        case (state_q)
            STATE_IDLE: begin
                if (clear_req) begin
                    state_d     = STATE_CLEAR;
                    start_clear = 1'b1;
                end else if (draw_req) begin
                    state_d     = STATE_PAINT;
                    accept_draw = 1'b1;
                end
            end
            STATE_PAINT: begin
                wx = px;
                wy = py;
                wd = lc;
                // Off-plane pixels still take their cycle, they just don't write.
                we = (32'(px) < WIDTH) && (32'(py) < HEIGHT);
                if (bx_last && by_last)
                    state_d = STATE_IDLE;
            end
            STATE_CLEAR: begin
                wx = {1'b0, cx};
                wy = {1'b0, cy};
                wd = COLOR_NONE;
                we = 1'b1;
                if (cx_last && cy_last)
                    state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    assign wa = AW'(wy) * AW'(WIDTH) + AW'(wx);

    // Read address; anything off the plane reads as transparent.
    assign rd_ok = (32'(request_x) < WIDTH) && (32'(request_y) < HEIGHT);
    assign ra    = AW'(request_y) * AW'(WIDTH) + AW'(request_x);

    // FSM state register and stamp/clear scan counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            bx      <= '0;
            by      <= '0;
            cx      <= '0;
            cy      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                STATE_IDLE: begin
                    if (accept_draw) begin
                        bx <= '0;
                        by <= '0;
                    end
                    if (start_clear) begin
                        cx <= '0;
                        cy <= '0;
                    end
                end
                STATE_PAINT: begin
                    if (bx_last) begin
                        bx <= '0;
                        by <= by_last ? '0 : by + BW'(1);
                    end else begin
                        bx <= bx + BW'(1);
                    end
                end
                STATE_CLEAR: begin
                    if (cx_last) begin
                        cx <= '0;
                        cy <= cy_last ? '0 : cy + YW'(1);
                    end else begin
                        cx <= cx + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture stamp parameters when a draw request is accepted.
    always_ff @(posedge clk) begin
        if (accept_draw) begin
            lx <= draw_x;
            ly <= draw_y;
            lc <= draw_color;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    // Registered read port; a same-cycle write is seen only on the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            canvas_color <= COLOR_NONE;
        else
            canvas_color <= rd_ok ? mem[ra] : COLOR_NONE;
    end

    // Layer enable flips on every cycle the toggle input is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            canvas_visible <= 1'b1;
        else if (visible_toggle)
            canvas_visible <= ~canvas_visible;
    end

endmodule

// File: tb/tb_canvas_layer.sv
// Directed self-checking bench for canvas_layer on an 8x8 plane, brush 2.
module tb_canvas_layer;

    localparam logic [3:0] NONE  = 4'h0;
    localparam logic [3:0] BLACK = 4'h1;
    localparam logic [3:0] RED   = 4'h4;
    localparam logic [3:0] WHITE = 4'hF;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] request_x, request_y;
    logic [3:0] canvas_color;
    logic       canvas_visible;
    logic       visible_toggle;
    logic       draw_req;
    logic [2:0] draw_x, draw_y;
    logic [3:0] draw_color;
    logic       clear_req;
    logic       busy;

    int total = 0;
    int bad   = 0;

    canvas_layer #(
        .WIDTH(8), .HEIGHT(8), .BRUSH(2), .COLOR_WIDTH(4), .COLOR_NONE(4'h0)
    ) dut (
        .clk(clk), .reset(reset),
        .request_x(request_x), .request_y(request_y),
        .canvas_color(canvas_color), .canvas_visible(canvas_visible),
        .visible_toggle(visible_toggle),
        .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y),
        .draw_color(draw_color), .clear_req(clear_req), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Present a read address, return the registered colour one cycle later.
    task automatic rd(input int x, input int y, output logic [3:0] c);
        request_x = 3'(x);
        request_y = 3'(y);
        @(posedge clk); #1;
        c = canvas_color;
    endtask

    // Count cycles busy stays high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        request_x = 0; request_y = 0;
        visible_toggle = 0; draw_req = 0; clear_req = 0;
        draw_x = 0; draw_y = 0; draw_color = NONE;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (canvas_visible !== 1'b1) begin bad++; $display("FAIL reset_visible got=%b want=1", canvas_visible); end
        total++; if (canvas_color !== NONE) begin bad++; $display("FAIL reset_color got=%h want=%h", canvas_color, NONE); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clear;
        int n;
        logic [3:0] c;
        int xs[3] = '{0, 7, 3};
        int ys[3] = '{0, 7, 5};
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        count_busy(n);
        total++; if (n != 64) begin bad++; $display("FAIL clear_busy_cycles got=%0d want=64", n); end
        for (int i = 0; i < 3; i++) begin
            rd(xs[i], ys[i], c);
            total++; if (c !== NONE) begin bad++; $display("FAIL clear_read_%0d_%0d got=%h want=%h", xs[i], ys[i], c, NONE); end
        end
    endtask

    task automatic test_stamp;
        int n;
        logic [3:0] c;
        int xs[6] = '{2, 3, 2, 3, 4, 2};
        int ys[6] = '{3, 3, 4, 4, 3, 5};
        logic [3:0] ex[6] = '{RED, RED, RED, RED, NONE, NONE};
        draw_x = 3'd2; draw_y = 3'd3; draw_color = RED; draw_req = 1'b1;
        @(posedge clk); #1;
        draw_req = 1'b0;
        // Latched parameters must not follow the inputs mid-stamp.
        draw_x = 3'd6; draw_y = 3'd0; draw_color = WHITE;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stamp_busy_start got=%b want=1", busy); end
        count_busy(n);
        total++; if (n != 4) begin bad++; $display("FAIL stamp_busy_cycles got=%0d want=4", n); end
        for (int i = 0; i < 6; i++) begin
            rd(xs[i], ys[i], c);
            total++; if (c !== ex[i]) begin bad++; $display("FAIL stamp_read_%0d_%0d got=%h want=%h", xs[i], ys[i], c, ex[i]); end
        end
    endtask

    task automatic test_edge_stamp;
        int n;
        logic [3:0] c;
        int xs[4] = '{7, 0, 0, 7};
        int ys[4] = '{7, 0, 7, 0};
        logic [3:0] ex[4] = '{WHITE, NONE, NONE, NONE};
        draw_x = 3'd7; draw_y = 3'd7; draw_color = WHITE; draw_req = 1'b1;
        @(posedge clk); #1;
        draw_req = 1'b0;
        count_busy(n);
        total++; if (n != 4) begin bad++; $display("FAIL edge_busy_cycles got=%0d want=4", n); end
        for (int i = 0; i < 4; i++) begin
            rd(xs[i], ys[i], c);
            total++; if (c !== ex[i]) begin bad++; $display("FAIL edge_read_%0d_%0d got=%h want=%h", xs[i], ys[i], c, ex[i]); end
        end
    endtask

    task automatic test_clear_priority;
        int n;
        logic [3:0] c;
        draw_x = 3'd5; draw_y = 3'd5; draw_color = RED;
        draw_req = 1'b1; clear_req = 1'b1;
        @(posedge clk); #1;
        draw_req = 1'b0; clear_req = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            if (n == 10) begin
                draw_x = 3'd1; draw_y = 3'd1; draw_color = RED; draw_req = 1'b1;
            end else begin
                draw_req = 1'b0;
            end
            n++;
            @(posedge clk); #1;
        end
        draw_req = 1'b0;
        total++; if (n != 64) begin bad++; $display("FAIL prio_busy_cycles got=%0d want=64", n); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_not_queued got=%b want=0", busy); end
        rd(1, 1, c);
        total++; if (c !== NONE) begin bad++; $display("FAIL prio_read_1_1 got=%h want=%h", c, NONE); end
        rd(5, 5, c);
        total++; if (c !== NONE) begin bad++; $display("FAIL prio_read_5_5 got=%h want=%h", c, NONE); end
        rd(2, 3, c);
        total++; if (c !== NONE) begin bad++; $display("FAIL prio_read_2_3 got=%h want=%h", c, NONE); end
    endtask

    task automatic test_reset_mid_stamp;
        logic [3:0] c;
        int xs[4] = '{0, 1, 0, 1};
        int ys[4] = '{0, 0, 1, 1};
        logic [3:0] ex[4] = '{BLACK, BLACK, NONE, NONE};
        request_x = 0; request_y = 0;
        draw_x = 3'd0; draw_y = 3'd0; draw_color = BLACK; draw_req = 1'b1;
        @(posedge clk); #1;
        draw_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
        total++; if (canvas_color !== NONE) begin bad++; $display("FAIL midreset_color got=%h want=%h", canvas_color, NONE); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rd(xs[i], ys[i], c);
            total++; if (c !== ex[i]) begin bad++; $display("FAIL midreset_read_%0d_%0d got=%h want=%h", xs[i], ys[i], c, ex[i]); end
        end
    endtask

    task automatic test_visible;
        logic [3:0] c;
        visible_toggle = 1'b1;
        @(posedge clk); #1;
        visible_toggle = 1'b0;
        total++; if (canvas_visible !== 1'b0) begin bad++; $display("FAIL visible_single got=%b want=0", canvas_visible); end
        visible_toggle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        visible_toggle = 1'b0;
        total++; if (canvas_visible !== 1'b1) begin bad++; $display("FAIL visible_triple got=%b want=1", canvas_visible); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL visible_busy got=%b want=0", busy); end
        rd(0, 0, c);
        total++; if (c !== BLACK) begin bad++; $display("FAIL visible_mem got=%h want=%h", c, BLACK); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_stamp();
        test_edge_stamp();
        test_clear_priority();
        test_reset_mid_stamp();
        test_visible();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/canvas_layer.md
Name: canvas_layer

Overview:
- One drawable overlay plane: a WIDTH×HEIGHT colour memory that feeds one canvasN_color/canvasN_visible pair of the compositor.
- Read side: serves the compositor's request_x/request_y with a registered 1-cycle read. This fits inside the compositor's two-cycle INCR/HOLD pixel period.
- Write side: accepts brush strokes (square BRUSH×BRUSH stamps) and whole-plane clears from the drawing controller, via a req/busy handshake.

Parameters:
- WIDTH, 640, plane width in pixels.
- HEIGHT, 480, plane height in pixels.
- BRUSH, 3, brush side length in pixels (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- request_x  in  $clog2(WIDTH)  read column, from the compositor.
- request_y  in  $clog2(HEIGHT)  read row, from the compositor.
- canvas_color  out  COLOR_WIDTH  colour at the previous cycle's request address.
- canvas_visible  out  1  layer enable, to the compositor.
- visible_toggle  in  1  flips canvas_visible for each cycle it is high.
- draw_req  in  1  request a brush stamp.
- draw_x  in  $clog2(WIDTH)  stamp top-left column.
- draw_y  in  $clog2(HEIGHT)  stamp top-left row.
- draw_color  in  COLOR_WIDTH  stamp colour.
- clear_req  in  1  request a fill of the whole plane with COLOR_NONE.
- busy  out  1  high while a stamp or clear is in progress; requests are ignored while high.

Behaviour:
- Reset values (asynchronous): state=STATE_IDLE, busy=0, canvas_visible=1, canvas_color=COLOR_NONE, all counters=0. Memory contents are not reset.
- Read path:
  - canvas_color <= mem[request_x][request_y] every cycle, in every state. Latency is 1 cycle.
  - A read and a write to the same address in the same cycle returns the old data (read-before-write).
  - Requests with out-of-range x≥WIDTH or y≥HEIGHT return COLOR_NONE.
- canvas_visible toggles on every clk edge where visible_toggle=1, independent of state.
- FSM states: STATE_IDLE, STATE_PAINT, STATE_CLEAR.
- STATE_IDLE:
  - clear_req=1 → STATE_CLEAR. This takes priority over a simultaneous draw_req, which is dropped.
  - Otherwise draw_req=1 → latch draw_x, draw_y, draw_color; set bx=by=0; go to STATE_PAINT.
  - busy=1 from the cycle after acceptance.
- STATE_PAINT:
  - One write per cycle to (lx+bx, ly+by).
  - Sums are computed one bit wider than the coordinate, so there is no wrap-around.
  - Writes with lx+bx≥WIDTH or ly+by≥HEIGHT are suppressed, but the cycle is still consumed.
  - bx increments first; at bx=BRUSH-1, bx←0 and by increments.
  - After the write at (BRUSH-1, BRUSH-1) → STATE_IDLE, busy=0.
  - Exactly BRUSH² cycles in STATE_PAINT.
- STATE_CLEAR:
  - Writes COLOR_NONE at (cx, cy), raster order with x as the inner loop.
  - After (WIDTH-1, HEIGHT-1) → STATE_IDLE.
  - Exactly WIDTH·HEIGHT cycles in STATE_CLEAR.
- draw_req/clear_req while busy=1 are ignored, not queued. Requesters must hold the request until they observe busy=1, or issue it only when busy=0.
- Reset mid-operation: the FSM returns to IDLE immediately. Pixels already written remain; the rest of the stamp/clear is abandoned.
- Latched stamp parameters are unaffected by draw_x/draw_y/draw_color changing during STATE_PAINT.

Optional Feature:
- Macro: CANVAS_CLEAR_ON_RESET_EN.
- Defined: on reset deassertion the FSM leaves reset in STATE_CLEAR with busy=1 and cx=cy=0. The plane is guaranteed all COLOR_NONE WIDTH·HEIGHT cycles after reset release.
- Not defined: the FSM leaves reset in STATE_IDLE, and the memory is undefined until the first clear_req completes.

Test Plan (WIDTH=8, HEIGHT=8, BRUSH=2):
- Reset, then clear_req for 1 cycle → busy high for 64 cycles; afterwards, reads of (0,0), (7,7) and (3,5) return COLOR_NONE one cycle after the request.
- draw_req at (2,3) with COLOR_RED → busy for 4 cycles; (2,3), (3,3), (2,4), (3,4) read COLOR_RED; (4,3) and (2,5) read COLOR_NONE.
- draw_req at (7,7) with COLOR_WHITE → 4 busy cycles; only (7,7) becomes COLOR_WHITE; (0,0) and (0,7) stay COLOR_NONE (no wrap).
- Simultaneous clear_req+draw_req in IDLE → 64-cycle clear, no stamp. A draw_req at (1,1) issued mid-clear is ignored, so (1,1) reads COLOR_NONE afterwards.
- Reset asserted 2 cycles into a stamp at (0,0) with COLOR_BLACK → busy=0 and canvas_color=COLOR_NONE immediately. (0,0) and (1,0) read COLOR_BLACK; (0,1) and (1,1) are unchanged.
- visible_toggle high for 1 cycle → canvas_visible 1→0; high for 3 consecutive cycles → ends at 1. No effect on busy or memory.
